// File: rtl/spi_dac_sequencer.sv
// SPI write engine for multi-channel serial reference DACs: snapshots all channel
// levels, shifts one framed word per channel, then pulses a shared load strobe.
module spi_dac_sequencer #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 8,
  parameter int FRAME_W  = 16,
  parameter int DATA_LSB = 4,
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 2,
  parameter bit GAIN_X1  = 1'b0,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     update,
  input  logic                     auto_en,
  input  logic [NUM_CH*DATA_W-1:0] levels,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  output logic                     ldac_n,
  output logic                     busy,
  output logic                     done,
  output logic [CH_W-1:0]          cur_ch
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W + 1);
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("spi_dac_sequencer: NUM_CH must be 1..8");
  end
  if (CLK_DIV < 1 || CS_GAP < 1) begin : g_bad_timing
    $error("spi_dac_sequencer: CLK_DIV and CS_GAP must be at least 1");
  end
  if (CH_W + 3 + DATA_LSB + DATA_W > FRAME_W) begin : g_bad_frame
    $error("spi_dac_sequencer: channel, header and data fields do not fit in FRAME_W");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    LATCH
  } state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   snap_q, snap_d;
  logic [FRAME_W-2:0]         shreg_q, shreg_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [GAP_W-1:0]           gap_q, gap_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       sclk_q, sclk_d;
  logic                       cs_n_q, cs_n_d;
  logic                       mosi_q, mosi_d;
  logic                       ldac_n_q, ldac_n_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       frame_end;
  logic [FRAME_W-1:0]         frame;

  // Frame word for the channel currently selected, built from the snapshot.
  always_comb begin
    frame = '0;
    frame[FRAME_W-1 -: CH_W]     = ch_q;
    frame[FRAME_W-CH_W-2]        = GAIN_X1;
    frame[FRAME_W-CH_W-3]        = 1'b1;
    frame[DATA_LSB +: DATA_W]    = snap_q[ch_q*DATA_W +: DATA_W];
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    shreg_d   = shreg_q;
    div_d     = div_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    ch_d      = ch_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    ldac_n_d  = ldac_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    frame_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (update || auto_en) begin
          snap_d  = levels;
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shreg_d = frame[FRAME_W-2:0];
        mosi_d  = frame[FRAME_W-1];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_W'(1);
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              cs_n_d = 1'b1;
              mosi_d = 1'b0;
              gap_d  = '0;
              // A single-cycle gap is covered by the LOAD cycle alone.
              if (CS_GAP > 1) state_d = GAP;
              else            frame_end = 1'b1;
            end else begin
              mosi_d  = shreg_q[FRAME_W-2];
              shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) frame_end = 1'b1;
        else                   gap_d = gap_q + GAP_W'(1);
      end

      LATCH: begin
        if (ldac_n_q) begin
          ldac_n_d = 1'b0;
          div_d    = '0;
        end else if (div_q == DIV_LAST) begin
          ldac_n_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          ch_d     = '0;
          state_d  = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      if (ch_q != LAST_CH) begin
        ch_d    = ch_q + CH_W'(1);
        state_d = LOAD;
      end else begin
        state_d = LATCH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      ch_q     <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      ch_q     <= ch_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      ldac_n_q <= ldac_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk   = sclk_q;
  assign cs_n   = cs_n_q;
  assign mosi   = mosi_q;
  assign ldac_n = ldac_n_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign cur_ch = ch_q;

endmodule
